c_lod_drain: RTL

Sequential set-bit serializer for the clib library. It accepts a request vector over a valid/ready load handshake. It then emits every set bit, leading bit (lowest index, bit 0 highest priority) first, one per output handshake, as a one-hot vector plus a binary index. Allocators and wake-up logic use it to walk a multi-bit request mask in leading-one order without replicating arbitration.

---
 rtl/c_lod_pkg.sv | 7 +
 rtl/c_lod_enc.sv | 29 ++
 rtl/c_lod_drain.sv | 48 ++++
 3 files changed

// File: rtl/c_lod_pkg.sv
// c_lod_pkg: shared state encoding and index-width helper for the leading-one drain
package c_lod_pkg;
  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;
  function automatic int clogb(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/c_lod_enc.sv
// c_lod_enc: leading-one detect (bit 0 first) with binary index and single-bit flag
module c_lod_enc import c_lod_pkg::*; #(
  parameter int width = 32,
  localparam int idx_width = clogb(width)
) (
  input  logic [0:width-1]     vec,
  output logic [0:width-1]     onehot,
  output logic [0:idx_width-1] index,
  output logic                 single
);
  logic [idx_width-1:0] idx;
  always_comb begin
    logic seen;
    seen = 1'b0;
    onehot = '0;
    for (int i = 0; i < width; i++) begin
      onehot[i] = vec[i] & ~seen;
      seen = seen | vec[i];
    end
  end
  always_comb begin
    idx = '0;
    for (int b = 0; b < idx_width; b++)
      for (int i = 0; i < width; i++)
        idx[b] = idx[b] | (onehot[i] & 1'(i >> b));
  end
  assign index = idx;
  assign single = (vec & ~onehot) == '0;
endmodule

// File: rtl/c_lod_drain.sv
// c_lod_drain: loads a request mask and emits its set bits one per handshake, lowest index first
module c_lod_drain import c_lod_pkg::*; #(
  parameter int width = 32,
  localparam int idx_width = clogb(width)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [0:width-1]     load_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:width-1]     out_onehot,
  output logic [0:idx_width-1] out_index,
  output logic                 out_last,
  output logic                 busy
);
  state_t state, nxt_state;
  logic [0:width-1] rem, nxt_rem, oh;
  logic [0:idx_width-1] idx;
  logic single, ld, tk;
  c_lod_enc #(.width(width)) u_enc (.vec(rem), .onehot(oh), .index(idx), .single(single));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rem <= '0;
    end else begin
      state <= nxt_state;
      rem <= nxt_rem;
    end
  end
  // flush wins over both handshakes; a zero vector is swallowed without leaving IDLE
  always_comb begin
    ld = state == IDLE && load_valid && |load_data;
    tk = state == DRAIN && out_ready;
    nxt_state = flush ? IDLE : ld ? DRAIN : (tk && single) ? IDLE : state;
    nxt_rem = flush ? '0 : ld ? load_data : tk ? rem & ~oh : rem;
  end
  always_comb begin
    busy = state == DRAIN;
    load_ready = ~busy;
    out_valid = busy;
    out_onehot = busy ? oh : '0;
    out_index = busy ? idx : '0;
    out_last = busy & single;
  end
endmodule
